// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared constants and state encoding for the binary-to-BCD block
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int          BCD_DIGITS  = 4;
    localparam int          MAX_DEC     = 9999;
    localparam logic [15:0] OVF_PATTERN = 16'hEEEE;
    localparam int          CNT_W       = 4;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SHIFT = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Request/result bundle between a producer and the BCD converter
// Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int IN_W = 14
);
    logic [IN_W-1:0]         bin_in;
    logic                    start;
    logic                    auto_en;
    logic [4*BCD_DIGITS-1:0] bcd_out;
    logic                    done;
    logic                    busy;
    logic                    ovf;

    modport master (
        output bin_in, start, auto_en,
        input  bcd_out, done, busy, ovf
    );

    modport slave (
        input  bin_in, start, auto_en,
        output bcd_out, done, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble nibble corrector (add 3 when the digit is >= 5)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  wire logic [3:0] din,
    output logic      [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, 1 bit/clock
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int IN_W    = 14,
    parameter int MAX_DEC = bcd_pkg::MAX_DEC
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bin_to_bcd_seq_if.slave bus
);
    import bcd_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
    localparam logic [31:0]      MAX_VAL  = 32'(MAX_DEC);

    logic [1:0]            state;
    logic [IN_W-1:0]       bin_sr;
    logic [15:0]           bcd_sr;
    logic [15:0]           bcd_adj;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf_pend;
    logic [15:0]           bcd_q;
    logic                  done_q;
    logic                  ovf_q;
    logic                  request;
    logic                  over_range;
    logic [16+IN_W-1:0]    shifted;

    assign request    = bus.start | bus.auto_en;
    assign over_range = (32'(bus.bin_in) > MAX_VAL);
    assign shifted    = {bcd_adj, bin_sr} << 1;

    generate
        for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
            bcd_digit_adj u_adj (
                .din  (bcd_sr[4*i +: 4]),
                .dout (bcd_adj[4*i +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        bin_sr   <= bus.bin_in;
                        bcd_sr   <= '0;
                        cnt      <= '0;
                        ovf_pend <= over_range;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_sr <= shifted[16+IN_W-1 -: 16];
                    bin_sr <= shifted[IN_W-1:0];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Only edge on which the visible result changes
                    bcd_q  <= ovf_pend ? OVF_PATTERN : bcd_sr;
                    ovf_q  <= ovf_pend;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = (state == ST_SHIFT) || (state == ST_DONE);

endmodule
`default_nettype wire
